// File: rtl/frame_generator.sv
// Avalon-MM programmable AXIS frame generator: beat 0 carries a sequence number, beat k carries seed+k.
// Registered readdata (1-cycle latency); tdata/tlast are held while tx_tready is low and those cycles are counted.
module frame_generator #(
   parameter int LEN_WIDTH = 11,
   parameter int GAP_WIDTH = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] writedata,
   input  logic        write,
   input  logic        chipselect,
   input  logic [7:0]  address,
   input  logic        read,
   output logic [31:0] readdata,
   output logic [15:0] tx_tdata,
   output logic        tx_tvalid,
   input  logic        tx_tready,
   output logic        tx_tlast,
   output logic        irq
);

   typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

   state_t               state_q, state_d;
   logic                 cont_q, cont_d;
   logic                 irq_en_q, irq_en_d;
   logic [LEN_WIDTH-1:0] frame_len_q, frame_len_d;
   logic [31:0]          num_frames_q, num_frames_d;
   logic [GAP_WIDTH-1:0] gap_q, gap_d;
   logic [15:0]          seed_q, seed_d;
   logic [LEN_WIDTH-1:0] beat_idx_q, beat_idx_d;
   logic [15:0]          seq_q, seq_d;
   logic [GAP_WIDTH-1:0] gap_cnt_q, gap_cnt_d;
   logic [31:0]          beats_q, beats_d;
   logic [31:0]          frames_q, frames_d;
   logic [31:0]          stall_q, stall_d;
   logic                 done_q, done_d;
   logic                 stop_pending_q, stop_pending_d;
   logic [31:0]          readdata_q, readdata_d;

   logic                 wr_en, rd_en, start_stb, stop_stb;
   logic [LEN_WIDTH-1:0] last_idx;
   logic                 busy;

   assign wr_en     = chipselect & write;
   assign rd_en     = chipselect & read;
   assign start_stb = wr_en && (address == 8'd0) && writedata[0];
   assign stop_stb  = wr_en && (address == 8'd0) && writedata[1];
   assign busy      = (state_q != IDLE);

   // A zero frame length behaves as a single-beat frame.
   assign last_idx  = (frame_len_q == '0) ? '0 : frame_len_q - LEN_WIDTH'(1);

   assign tx_tvalid = (state_q == SEND);
   assign tx_tlast  = tx_tvalid && (beat_idx_q == last_idx);
   assign tx_tdata  = !tx_tvalid          ? 16'h0000 :
                      (beat_idx_q == '0)  ? seq_q    :
                                            seed_q + 16'(beat_idx_q);
   assign irq       = done_q & irq_en_q;
   assign readdata  = readdata_q;

   always_comb begin
      state_d        = state_q;
      cont_d         = cont_q;
      irq_en_d       = irq_en_q;
      frame_len_d    = frame_len_q;
      num_frames_d   = num_frames_q;
      gap_d          = gap_q;
      seed_d         = seed_q;
      beat_idx_d     = beat_idx_q;
      seq_d          = seq_q;
      gap_cnt_d      = gap_cnt_q;
      beats_d        = beats_q;
      frames_d       = frames_q;
      stall_d        = stall_q;
      done_d         = done_q;
      stop_pending_d = stop_pending_q;
      readdata_d     = readdata_q;

      if (wr_en && address == 8'd0) begin
         cont_d   = writedata[2];
         irq_en_d = writedata[3];
      end
      // Run parameters are frozen while a run is in progress.
      if (wr_en && !busy) begin
         case (address)
            8'd1:    frame_len_d  = writedata[LEN_WIDTH-1:0];
            8'd2:    num_frames_d = writedata;
            8'd3:    gap_d        = writedata[GAP_WIDTH-1:0];
            8'd4:    seed_d       = writedata[15:0];
            default: ;
         endcase
      end

      case (state_q)
         IDLE: begin
            if (start_stb && (cont_d || num_frames_q != 32'd0)) begin
               state_d        = SEND;
               beats_d        = 32'd0;
               frames_d       = 32'd0;
               stall_d        = 32'd0;
               done_d         = 1'b0;
               stop_pending_d = 1'b0;
               beat_idx_d     = '0;
               seq_d          = 16'd0;
            end
         end
         SEND: begin
            if (stop_stb) stop_pending_d = 1'b1;
            if (!tx_tready) begin
               stall_d = stall_q + 32'd1;
            end else begin
               beats_d = beats_q + 32'd1;
               if (tx_tlast) begin
                  frames_d   = frames_q + 32'd1;
                  seq_d      = seq_q + 16'd1;
                  beat_idx_d = '0;
                  if (stop_pending_q || stop_stb ||
                      (!cont_q && (frames_q + 32'd1 == num_frames_q))) begin
                     state_d = IDLE;
                     done_d  = 1'b1;
                  end else if (gap_q != '0) begin
                     state_d   = GAP;
                     gap_cnt_d = '0;
                  end
               end else begin
                  beat_idx_d = beat_idx_q + LEN_WIDTH'(1);
               end
            end
         end
         GAP: begin
            if (stop_stb || stop_pending_q) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end else if (gap_cnt_q == gap_q - GAP_WIDTH'(1)) begin
               state_d = SEND;
            end else begin
               gap_cnt_d = gap_cnt_q + GAP_WIDTH'(1);
            end
         end
         default: state_d = IDLE;
      endcase

      if (rd_en) begin
         case (address)
            8'd0:    readdata_d = {28'd0, irq_en_q, cont_q, 2'b00};
            8'd1:    readdata_d = 32'(frame_len_q);
            8'd2:    readdata_d = num_frames_q;
            8'd3:    readdata_d = 32'(gap_q);
            8'd4:    readdata_d = {16'd0, seed_q};
            8'd5:    readdata_d = {29'd0, stop_pending_q, done_q, busy};
            8'd6:    readdata_d = beats_q;
            8'd7:    readdata_d = frames_q;
            8'd8:    readdata_d = stall_q;
            default: readdata_d = 32'd0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= IDLE;
         cont_q         <= 1'b0;
         irq_en_q       <= 1'b0;
         frame_len_q    <= LEN_WIDTH'(1);
         num_frames_q   <= 32'd0;
         gap_q          <= '0;
         seed_q         <= 16'd0;
         beat_idx_q     <= '0;
         seq_q          <= 16'd0;
         gap_cnt_q      <= '0;
         beats_q        <= 32'd0;
         frames_q       <= 32'd0;
         stall_q        <= 32'd0;
         done_q         <= 1'b0;
         stop_pending_q <= 1'b0;
         readdata_q     <= 32'd0;
      end else begin
         state_q        <= state_d;
         cont_q         <= cont_d;
         irq_en_q       <= irq_en_d;
         frame_len_q    <= frame_len_d;
         num_frames_q   <= num_frames_d;
         gap_q          <= gap_d;
         seed_q         <= seed_d;
         beat_idx_q     <= beat_idx_d;
         seq_q          <= seq_d;
         gap_cnt_q      <= gap_cnt_d;
         beats_q        <= beats_d;
         frames_q       <= frames_d;
         stall_q        <= stall_d;
         done_q         <= done_d;
         stop_pending_q <= stop_pending_d;
         readdata_q     <= readdata_d;
      end
   end

endmodule

// File: tb/tb_frame_generator.sv
// Self-checking bench for frame_generator: register programming over Avalon-MM, AXIS stream
// compared against a frame-list model built from the programmed length, count, gap and seed.
module tb_frame_generator;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] writedata;
   logic        write;
   logic        chipselect;
   logic [7:0]  address;
   logic        read;
   logic [31:0] readdata;
   logic [15:0] tx_tdata;
   logic        tx_tvalid;
   logic        tx_tready;
   logic        tx_tlast;
   logic        irq;

   frame_generator #(.LEN_WIDTH(11), .GAP_WIDTH(8)) dut (
      .clk        (clk),
      .reset      (reset),
      .writedata  (writedata),
      .write      (write),
      .chipselect (chipselect),
      .address    (address),
      .read       (read),
      .readdata   (readdata),
      .tx_tdata   (tx_tdata),
      .tx_tvalid  (tx_tvalid),
      .tx_tready  (tx_tready),
      .tx_tlast   (tx_tlast),
      .irq        (irq)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Every cycle with tvalid high is logged; the model is applied afterwards.
   typedef struct {
      logic [15:0] d;
      logic        l;
      logic        r;
      int          c;
   } rec_t;
   rec_t recs[$];
   int   hs_count = 0;

   always @(negedge clk) begin
      if (!reset && tx_tvalid) begin
         recs.push_back('{tx_tdata, tx_tlast, tx_tready, cyc});
         if (tx_tready) hs_count++;
      end
   end

   // Ready driver: either always ready, random, or a forced stall before a chosen handshake.
   bit rand_ready = 1'b0;
   int stall_at   = -1;
   int stall_req  = 0;
   int stall_used = 0;

   initial begin
      tx_tready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         if (hs_count == stall_at && stall_used < stall_req) begin
            tx_tready = 1'b0;
            stall_used++;
         end else begin
            if (hs_count != stall_at) stall_used = 0;
            tx_tready = rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
         end
      end
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation did not finish, time %0t, required completion", $time);
      $fatal(1, "watchdog");
   end

   task automatic av_write(input logic [7:0] a, input logic [31:0] d);
      chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
      @(posedge clk);
      #1;
      chipselect = 1'b0; write = 1'b0;
   endtask

   task automatic av_read(input logic [7:0] a, output logic [31:0] d);
      chipselect = 1'b1; read = 1'b1; address = a;
      @(posedge clk);
      #1;
      chipselect = 1'b0; read = 1'b0;
      d = readdata;
   endtask

   task automatic program_run(input int len, input int n, input int gap, input logic [15:0] seed);
      av_write(8'd1, 32'(len));
      av_write(8'd2, 32'(n));
      av_write(8'd3, 32'(gap));
      av_write(8'd4, {16'd0, seed});
   endtask

   task automatic wait_idle(output bit ok);
      logic [31:0] st;
      ok = 1'b0;
      for (int t = 0; t < 3000; t++) begin
         av_read(8'd5, st);
         if (st[0] == 1'b0) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic wait_hs(input int target, output bit ok);
      int t = 0;
      while (hs_count < target && t < 2000) begin
         @(posedge clk);
         #2;
         t++;
      end
      ok = (hs_count >= target);
   endtask

   // Reference stream: nfr frames of max(len,1) beats; beat 0 = frame number, beat k = seed+k.
   // Valid must stay up inside a frame and drop for exactly gap cycles after each tlast handshake.
   function automatic int stream_bad(input int len, input int nfr, input logic [15:0] seed,
                                     input int gap, input int base);
      logic [15:0] exp_d[$];
      logic        exp_l[$];
      int eff = (len == 0) ? 1 : len;
      int pos = 0;
      int bad = 0;
      for (int f = 0; f < nfr; f++)
         for (int k = 0; k < eff; k++) begin
            exp_d.push_back((k == 0) ? 16'(f) : 16'(int'(seed) + k));
            exp_l.push_back(k == eff - 1);
         end
      for (int i = base; i < recs.size(); i++) begin
         if (pos >= exp_d.size()) begin
            bad++;
            continue;
         end
         if (recs[i].d !== exp_d[pos] || recs[i].l !== exp_l[pos]) bad++;
         if (i > base) begin
            int expc = (recs[i-1].r && recs[i-1].l) ? recs[i-1].c + gap + 1 : recs[i-1].c + 1;
            if (recs[i].c != expc) bad++;
         end
         if (recs[i].r) pos++;
      end
      if (pos != exp_d.size()) bad++;
      return bad;
   endfunction

   function automatic int stalls_since(input int base);
      int s = 0;
      for (int i = base; i < recs.size(); i++)
         if (!recs[i].r) s++;
      return s;
   endfunction

   task automatic test_reset();
      logic [31:0] rd;
      reset = 1'b1; write = 1'b0; read = 1'b0; chipselect = 1'b0;
      address = 8'd0; writedata = 32'd0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      checks++; if (readdata !== 32'd0) begin errors++; $display("FAIL reset_readdata: got %h want 0", readdata); end
      checks++; if (tx_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid: got %b want 0", tx_tvalid); end
      checks++; if (tx_tlast !== 1'b0) begin errors++; $display("FAIL reset_tlast: got %b want 0", tx_tlast); end
      checks++; if (tx_tdata !== 16'd0) begin errors++; $display("FAIL reset_tdata: got %h want 0", tx_tdata); end
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b want 0", irq); end
      av_read(8'd1, rd);
      checks++; if (rd !== 32'd1) begin errors++; $display("FAIL reset_frame_len: got %0d want 1", rd); end
      av_read(8'd2, rd);
      checks++; if (rd !== 32'd0) begin errors++; $display("FAIL reset_num_frames: got %0d want 0", rd); end
      av_read(8'd5, rd);
      checks++; if (rd !== 32'd0) begin errors++; $display("FAIL reset_status: got %h want 0", rd); end
      av_read(8'd0, rd);
      checks++; if (rd !== 32'd0) begin errors++; $display("FAIL reset_ctrl: got %h want 0", rd); end
   endtask

   task automatic test_basic();
      logic [31:0] rd;
      bit ok;
      int base;
      program_run(4, 2, 0, 16'h0100);
      base = recs.size();
      av_write(8'd0, 32'h1);
      wait_idle(ok);
      checks++; if (!ok) begin errors++; $display("FAIL basic_idle: busy never cleared, want idle"); end
      checks++; if (stream_bad(4, 2, 16'h0100, 0, base) !== 0) begin errors++;
         $display("FAIL basic_stream: %0d bad beats, want 0", stream_bad(4, 2, 16'h0100, 0, base)); end
      av_read(8'd7, rd);
      checks++; if (rd !== 32'd2) begin errors++; $display("FAIL basic_frames: got %0d want 2", rd); end
      av_read(8'd6, rd);
      checks++; if (rd !== 32'd8) begin errors++; $display("FAIL basic_beats: got %0d want 8", rd); end
      av_read(8'd5, rd);
      checks++; if (rd !== 32'h2) begin errors++; $display("FAIL basic_status: got %h want 2", rd); end
   endtask

   task automatic test_stall();
      logic [31:0] rd;
      bit ok;
      int base;
      program_run(4, 2, 0, 16'h0100);
      base = recs.size();
      stall_req = 3;
      stall_at  = hs_count + 1;
      av_write(8'd0, 32'h1);
      wait_idle(ok);
      stall_at = -1;
      checks++; if (!ok) begin errors++; $display("FAIL stall_idle: busy never cleared, want idle"); end
      checks++; if (stream_bad(4, 2, 16'h0100, 0, base) !== 0) begin errors++;
         $display("FAIL stall_stream: %0d bad beats, want 0", stream_bad(4, 2, 16'h0100, 0, base)); end
      av_read(8'd8, rd);
      checks++; if (rd !== 32'd3) begin errors++; $display("FAIL stall_cycles: got %0d want 3", rd); end
   endtask

   task automatic test_gap();
      logic [31:0] rd;
      bit ok;
      int base, hs_base;
      program_run(2, 3, 5, 16'h2000);
      base = recs.size();
      hs_base = hs_count;
      av_write(8'd0, 32'h1);
      wait_hs(hs_base + 6, ok);
      checks++; if (!ok) begin errors++; $display("FAIL gap_handshakes: got %0d want %0d", hs_count - hs_base, 6); end
      av_read(8'd5, rd);
      checks++; if (rd[0] !== 1'b0) begin errors++; $display("FAIL gap_after_last: busy %b want 0", rd[0]); end
      wait_idle(ok);
      checks++; if (stream_bad(2, 3, 16'h2000, 5, base) !== 0) begin errors++;
         $display("FAIL gap_stream: %0d bad beats, want 0", stream_bad(2, 3, 16'h2000, 5, base)); end
      av_read(8'd7, rd);
      checks++; if (rd !== 32'd3) begin errors++; $display("FAIL gap_frames: got %0d want 3", rd); end
   endtask

   task automatic test_continuous_stop();
      logic [31:0] rd;
      bit ok;
      int base, hs_base;
      program_run(3, 0, 0, 16'h0055);
      av_write(8'd0, 32'hC);
      base = recs.size();
      hs_base = hs_count;
      av_write(8'd0, 32'hD);
      av_write(8'd1, 32'd7);
      wait_hs(hs_base + 10, ok);
      checks++; if (!ok) begin errors++; $display("FAIL cont_handshakes: got %0d want 10", hs_count - hs_base); end
      av_write(8'd0, 32'hE);
      wait_idle(ok);
      checks++; if (!ok) begin errors++; $display("FAIL cont_idle: busy never cleared, want idle"); end
      checks++; if (stream_bad(3, 4, 16'h0055, 0, base) !== 0) begin errors++;
         $display("FAIL cont_stream: %0d bad beats, want 0", stream_bad(3, 4, 16'h0055, 0, base)); end
      av_read(8'd7, rd);
      checks++; if (rd !== 32'd4) begin errors++; $display("FAIL cont_frames: got %0d want 4", rd); end
      checks++; if (irq !== 1'b1) begin errors++; $display("FAIL cont_irq: got %b want 1", irq); end
      av_read(8'd1, rd);
      checks++; if (rd !== 32'd3) begin errors++; $display("FAIL cont_busy_write: frame_len %0d want 3", rd); end
      av_write(8'd0, 32'h0);
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_mask: got %b want 0", irq); end
   endtask

   task automatic test_len0_nostart();
      logic [31:0] rd;
      bit ok;
      int base;
      program_run(0, 3, 0, 16'h0007);
      base = recs.size();
      av_write(8'd0, 32'h1);
      wait_idle(ok);
      checks++; if (stream_bad(0, 3, 16'h0007, 0, base) !== 0) begin errors++;
         $display("FAIL len0_stream: %0d bad beats, want 0", stream_bad(0, 3, 16'h0007, 0, base)); end
      av_read(8'd6, rd);
      checks++; if (rd !== 32'd3) begin errors++; $display("FAIL len0_beats: got %0d want 3", rd); end
      av_write(8'd2, 32'd0);
      base = recs.size();
      av_write(8'd0, 32'h1);
      repeat (4) @(posedge clk);
      #1;
      av_read(8'd5, rd);
      checks++; if (rd !== 32'h2) begin errors++; $display("FAIL nostart_status: got %h want 2", rd); end
      checks++; if (recs.size() !== base) begin errors++; $display("FAIL nostart_beats: got %0d want 0", recs.size() - base); end
   endtask

   task automatic test_random();
      logic [31:0] rd;
      bit ok;
      int base, len, n, gap, eff;
      logic [15:0] seed;
      rand_ready = 1'b1;
      for (int it = 0; it < 4; it++) begin
         len  = $urandom_range(0, 6);
         n    = $urandom_range(1, 3);
         gap  = $urandom_range(0, 3);
         seed = 16'($urandom);
         eff  = (len == 0) ? 1 : len;
         program_run(len, n, gap, seed);
         base = recs.size();
         av_write(8'd0, 32'h1);
         wait_idle(ok);
         checks++; if (!ok) begin errors++; $display("FAIL rand_idle[%0d]: busy never cleared, want idle", it); end
         checks++; if (stream_bad(len, n, seed, gap, base) !== 0) begin errors++;
            $display("FAIL rand_stream[%0d]: %0d bad beats, want 0", it, stream_bad(len, n, seed, gap, base)); end
         av_read(8'd6, rd);
         checks++; if (rd !== 32'(n * eff)) begin errors++; $display("FAIL rand_beats[%0d]: got %0d want %0d", it, rd, n * eff); end
         av_read(8'd8, rd);
         checks++; if (rd !== 32'(stalls_since(base))) begin errors++;
            $display("FAIL rand_stalls[%0d]: got %0d want %0d", it, rd, stalls_since(base)); end
      end
      rand_ready = 1'b0;
   endtask

   task automatic test_reset_mid();
      logic [31:0] rd;
      bit ok;
      program_run(20, 1, 0, 16'h0000);
      av_write(8'd0, 32'h1);
      wait_hs(hs_count + 5, ok);
      reset = 1'b1;
      @(posedge clk);
      #1;
      checks++; if (tx_tvalid !== 1'b0) begin errors++; $display("FAIL midreset_tvalid: got %b want 0", tx_tvalid); end
      reset = 1'b0;
      av_read(8'd7, rd);
      checks++; if (rd !== 32'd0) begin errors++; $display("FAIL midreset_frames: got %0d want 0", rd); end
      av_read(8'd6, rd);
      checks++; if (rd !== 32'd0) begin errors++; $display("FAIL midreset_beats: got %0d want 0", rd); end
      av_read(8'd1, rd);
      checks++; if (rd !== 32'd1) begin errors++; $display("FAIL midreset_frame_len: got %0d want 1", rd); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_stall();
      test_gap();
      test_continuous_stop();
      test_len0_nostart();
      test_random();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/frame_generator.md
FRAME_GENERATOR -- requirements
Module: frame_generator

Interface
REQ-001 Parameter LEN_WIDTH, default 11: width of the frame-length register, in beats.
REQ-002 Parameter GAP_WIDTH, default 8: width of the inter-frame gap register, in cycles.
REQ-003 clk  input  1  clock; all logic on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 writedata  input  32  Avalon-MM write data.
REQ-006 write  input  1  Avalon-MM write strobe.
REQ-007 chipselect  input  1  Avalon-MM select; read and write act only when it is high.
REQ-008 address  input  8  Avalon-MM word address.
REQ-009 read  input  1  Avalon-MM read strobe.
REQ-010 readdata  output  32  Avalon-MM read data, registered.
REQ-011 tx_tdata  output  16  AXIS master data.
REQ-012 tx_tvalid  output  1  AXIS master valid.
REQ-013 tx_tready  input  1  AXIS slave ready.
REQ-014 tx_tlast  output  1  AXIS last beat of frame.
REQ-015 irq  output  1  level interrupt, = done AND irq_en.

Function
REQ-016 Register map (address : mode : meaning):
- 0 : RW : ctrl. Bit0 start (write-1 strobe, reads 0). Bit1 stop (write-1 strobe, reads 0). Bit2 continuous. Bit3 irq_en.
- 1 : RW : frame_len[LEN_WIDTH-1:0].
- 2 : RW : num_frames[31:0].
- 3 : RW : gap[GAP_WIDTH-1:0].
- 4 : RW : seed[15:0].
- 5 : R : status. Bit0 busy, bit1 done, bit2 stop_pending.
- 6 : R : beats_sent.
- 7 : R : frames_sent.
- 8 : R : stall_cycles.
- Any other address reads 0; writes to it are ignored.
REQ-017 Read latency: readdata updates on the edge after chipselect AND read, and holds its value otherwise.
REQ-018 Writes to addresses 1-4 while busy are ignored; ctrl bits 2-3 are always writable.
REQ-019 FSM states IDLE, SEND, GAP; busy = (state != IDLE).
REQ-020 IDLE -> SEND on a start strobe when continuous=1 or num_frames != 0.
- On that transition: clear beats_sent, frames_sent, stall_cycles, done, stop_pending, beat index, and sequence number.
- A start strobe with num_frames=0 and continuous=0 is ignored.
REQ-021 A start strobe while busy is ignored.
REQ-022 In SEND, tx_tvalid=1.
- Beat 0: tx_tdata = sequence number [15:0].
- Beat k (k>=1): tx_tdata = seed + k, mod 2^16.
REQ-023 tx_tlast=1 exactly on beat index eff_len-1, where eff_len = max(frame_len, 1).
REQ-024 While tx_tvalid=1 and tx_tready=0, tx_tdata and tx_tlast hold stable and stall_cycles increments.
REQ-025 On each handshake (tvalid AND tready), beats_sent increments and the beat index advances.
REQ-026 On a tlast handshake:
- frames_sent and the sequence number increment; the beat index returns to 0.
- If stop_pending, or (continuous=0 and frames_sent+1 == num_frames): go to IDLE and set done.
- Else if gap=0: stay in SEND; the next frame's beat 0 is presented the next cycle.
- Else: go to GAP.
REQ-027 GAP holds tx_tvalid=0 for exactly gap cycles, then returns to SEND.
- A stop strobe or stop_pending in GAP -> IDLE on the next edge, with done set.
REQ-028 A stop strobe in SEND sets stop_pending; the current frame always completes with tlast. A stop strobe in IDLE has no effect.
REQ-029 A simultaneous stop strobe and tlast handshake ends the run at that frame.
REQ-030 All counters are 32-bit and wrap modulo 2^32; the sequence number wraps modulo 2^16.
REQ-031 The done bit is sticky; it clears only on an accepted start or on reset.

Reset
REQ-032 Reset values:
- Outputs: readdata=0, tx_tvalid=0, tx_tlast=0, tx_tdata=0, irq=0.
- Registers: ctrl bits=0, frame_len=1, num_frames=0, gap=0, seed=0.
- All counters=0; FSM=IDLE.
REQ-033 Reset asserted mid-frame drops tx_tvalid at the next edge; no frame completion is counted.

Verification
REQ-034 frame_len=4, num_frames=2, gap=0, seed=0x100, tready=1, start -> tdata 0x0000,0x0101,0x0102,0x0103(tlast),0x0001,0x0101,0x0102,0x0103(tlast); then frames_sent=2, beats_sent=8, done=1.
REQ-035 Same setup with tready low for 3 cycles on beat 1 -> tdata/tlast held stable throughout; stall_cycles=3; output sequence unchanged.
REQ-036 frame_len=2, gap=5, num_frames=3 -> exactly 5 idle cycles between each tlast and the next beat 0; no gap after the final frame.
REQ-037 continuous=1, frame_len=3, stop strobe on beat 1 of frame 4 -> frame 4 ends with tlast, frames_sent=4, busy=0, irq=1 when irq_en=1.
REQ-038 frame_len=0 -> single-beat frames with tlast on every beat; start with num_frames=0 and continuous=0 -> busy stays 0.
REQ-039 Reset mid-frame -> tx_tvalid=0 the next cycle; readback of address 7 returns 0.
